imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Responder end of the fetch-side instruction memory interface: accepts `mem_req_addr`/`mem_req_stb` from the fetch stage and returns `mem_req_data`/`mem_req_valid`.
- Hits return data combinationally in the same cycle, which preserves the fetch stage's single-cycle timing.
- Misses run a refill FSM that reads a full line from a backing memory over a simple rd/ack bus.
- Sits between the fetch stage and the backing instruction store. Also exports hit/miss performance counters.

Parameters:
- LINES, 16, number of direct-mapped lines (power of 2, >=2).
- LINE_WORDS, 4, 32-bit words per line (power of 2, >=2).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_reset  input  1  asynchronous active-high reset.
- mem_req_addr  input  32  fetch byte address; bits [1:0] ignored.
- mem_req_stb  input  1  fetch request strobe.
- mem_req_data  output  32  instruction word; 0 when mem_req_valid=0.
- mem_req_valid  output  1  data valid for the current-cycle request.
- inval  input  1  invalidate entire cache.
- bk_addr  output  32  backing read byte address, word aligned.
- bk_rd  output  1  backing read request; held until bk_ack.
- bk_rdata  input  32  backing read data, sampled when bk_ack=1.
- bk_ack  input  1  backing read complete; only meaningful while bk_rd=1.
- hit_count  output  32  saturating count of valid responses.
- miss_count  output  32  saturating count of miss events.

Behaviour:
- Address split:
  - offset = addr[OB+1:2], where OB = log2(LINE_WORDS).
  - index = addr[OB+IB+1:OB+2], where IB = log2(LINES).
  - tag = the remaining upper bits.
- Storage:
  - data array: LINES*LINE_WORDS x 32, asynchronous read.
  - tag array with per-line valid bit.
  - valid bits are flops cleared by reset.
- Reset (asynchronous):
  - state=IDLE, all valid bits=0, bk_rd=0, bk_addr=0, word counter=0.
  - hit_count=0, miss_count=0.
  - Data and tag arrays are not cleared.
- hit = valid[index] && tag_array[index]==tag.
- mem_req_valid = (state==IDLE) && mem_req_stb && hit. Combinational, zero latency.
- mem_req_data = data[index][offset] when mem_req_valid, else 32'h0.
- IDLE:
  - mem_req_stb && !hit: latch the line base address (addr with offset and byte bits zeroed), increment miss_count, and go to REFILL.
  - On the next cycle bk_rd=1 and bk_addr=base.
- REFILL:
  - bk_rd stays 1; bk_addr = base + 4*cnt, stable until bk_ack.
  - On bk_ack: write bk_rdata to data[line][cnt], cnt++, and present the next address on the following cycle (back-to-back, no idle cycle).
  - On the ack for cnt = LINE_WORDS-1: write the tag, set valid (unless killed), clear cnt, drop bk_rd, return to IDLE.
  - mem_req_valid is 0 for the whole REFILL state.
- Miss-to-hit latency with zero-wait ack: the request seen at cycle 0 hits at cycle LINE_WORDS+1.
- Fetch address changes or stb drops during REFILL: the current refill still completes for the latched line. The new address is evaluated on return to IDLE.
- inval:
  - In IDLE: all valid bits clear at the edge. mem_req_valid is still computed from the pre-edge valid bits in that cycle.
  - During REFILL: a sticky kill flag is set. The burst completes (the bus cannot abort) but the line is left invalid; the kill flag clears on return to IDLE.
  - inval on the same cycle as the final ack also leaves the line invalid.
- Counters:
  - hit_count increments every cycle mem_req_valid=1.
  - miss_count increments per miss event, not per refill cycle.
  - Both saturate at 32'hFFFF_FFFF.
- Reset mid-refill: FSM returns to IDLE immediately and bk_rd drops asynchronously. Any partially filled line stays invalid.

Test Plan:
1. Reset, stb=1, addr=0x100 → valid=0; miss_count=1; bk_rd rises next cycle with bk_addr=0x100, 0x104, 0x108, 0x10C under zero-wait ack returning 0xA0..0xA3; at cycle 5 valid=1, data=0xA0.
2. After 1, addr=0x108 → same-cycle valid=1, data=0xA2, hit_count increments; addr=0x10E → data=0xA3 (bits [1:0] ignored).
3. Conflict: fill 0x100, then request 0x200 (same index 0, tag 0x2) → refill from 0x200; then 0x100 → miss again, miss_count=3.
4. Backing wait states: bk_ack held low 3 cycles per word → bk_rd and bk_addr stay stable; valid stays 0 until the line completes.
5. inval asserted mid-refill of 0x100 → burst finishes all 4 reads; the next request to 0x100 misses and a new refill starts. inval in IDLE after a fill → the next access to 0x100 misses.
6. i_reset pulsed during the 2nd word of a refill → bk_rd=0 immediately; after release, 0x100 misses, refills from word 0, and hit/miss counters are 0 before the new miss.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder: direct-mapped instruction cache responder with combinational hits and a line-refill FSM
module imem_responder #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] mem_req_addr,
  input  logic        mem_req_stb,
  output logic [31:0] mem_req_data,
  output logic        mem_req_valid,
  input  logic        inval,
  output logic [31:0] bk_addr,
  output logic        bk_rd,
  input  logic [31:0] bk_rdata,
  input  logic        bk_ack,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TW = 30 - OB - IB;
  typedef enum logic {IDLE, REFILL} state_e;
  state_e          state_q;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]   tag_q [LINES];
  logic [31:0]     data_q [LINES*LINE_WORDS];
  logic [OB-1:0]   cnt_q;
  logic            kill_q;
  logic [IB-1:0]   line_q;
  logic [TW-1:0]   ltag_q;
  logic [OB-1:0]   off;
  logic [IB-1:0]   idx;
  logic [TW-1:0]   tag;
  logic            hit, last, unused_bits;
  assign off           = mem_req_addr[OB+1:2];
  assign idx           = mem_req_addr[OB+IB+1:OB+2];
  assign tag           = mem_req_addr[31:OB+IB+2];
  assign unused_bits   = ^mem_req_addr[1:0];
  assign hit           = valid_q[idx] && tag_q[idx] == tag;
  assign mem_req_valid = state_q == IDLE && mem_req_stb && hit;
  assign mem_req_data  = mem_req_valid ? data_q[{idx, off}] : 32'h0;
  assign last          = bk_ack && cnt_q == '1;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      bk_rd      <= 1'b0;
      bk_addr    <= '0;
      cnt_q      <= '0;
      kill_q     <= 1'b0;
      line_q     <= '0;
      ltag_q     <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (mem_req_valid && hit_count != '1) hit_count <= hit_count + 32'd1;
      if (inval) valid_q <= '0;
      if (state_q == IDLE) begin
        if (mem_req_stb && !hit) begin
          state_q <= REFILL;
          bk_rd   <= 1'b1;
          bk_addr <= {mem_req_addr[31:OB+2], {(OB+2){1'b0}}};
          line_q  <= idx;
          ltag_q  <= tag;
          if (miss_count != '1) miss_count <= miss_count + 32'd1;
        end
      end else begin
        kill_q <= kill_q | inval;
        if (bk_ack) begin
          cnt_q   <= cnt_q + 1'b1;
          bk_addr <= bk_addr + 32'd4;
        end
        // an invalidate seen at any point of the burst, including the final ack, keeps the line invalid
        if (last) begin
          state_q         <= IDLE;
          bk_rd           <= 1'b0;
          kill_q          <= 1'b0;
          valid_q[line_q] <= !(kill_q || inval);
        end
      end
    end
  always_ff @(posedge i_clk)
    if (state_q == REFILL && bk_ack) begin
      data_q[{line_q, cnt_q}] <= bk_rdata;
      if (cnt_q == '1) tag_q[line_q] <= ltag_q;
    end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: randomized and directed scoreboard bench against a cache-level reference model
module tb_imem_responder;
  logic        i_clk = 0, i_reset = 1;
  logic [31:0] mem_req_addr = 0, bk_rdata = 0;
  logic        mem_req_stb = 0, inval = 0, bk_ack = 0;
  logic [31:0] mem_req_data, bk_addr, hit_count, miss_count;
  logic        mem_req_valid, bk_rd;
  imem_responder dut (
    .i_clk(i_clk), .i_reset(i_reset), .mem_req_addr(mem_req_addr), .mem_req_stb(mem_req_stb),
    .mem_req_data(mem_req_data), .mem_req_valid(mem_req_valid), .inval(inval),
    .bk_addr(bk_addr), .bk_rd(bk_rd), .bk_rdata(bk_rdata), .bk_ack(bk_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );
  always #5 i_clk = ~i_clk;
  typedef struct {int cyc; logic [31:0] d;} exp_t;
  exp_t        q[$];
  int          checks = 0, failures = 0, cyc = 0;
  logic [15:0] mv = '0;
  logic [23:0] mt [16];
  logic        mrefill = 0, mkill = 0;
  logic [31:0] mbase = 0, mhits = 0, mmiss = 0;
  int          mcnt = 0;
  function automatic logic [31:0] bkf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", n, cyc, act, exp);
    end
  endtask
  task automatic step(input logic s, input logic [31:0] a, input logic inv, input logic ack);
    int          ix, li;
    logic [31:0] ea;
    mem_req_stb = s; mem_req_addr = a; inval = inv; bk_ack = 0; bk_rdata = 0;
    ix = int'((a >> 4) & 32'hF);
    if (!mrefill) begin
      chk("idle_bk_rd", bk_rd, 0);
      if (s && mv[ix] && mt[ix] == a[31:8]) begin
        q.push_back('{cyc, bkf(a & ~32'h3)});
        mhits++;
      end else if (s) begin
        mmiss++; mrefill = 1; mbase = a & ~32'hF; mcnt = 0; mkill = 0;
      end
      if (inv) mv = '0;
    end else begin
      ea = mbase + 32'(4 * mcnt);
      chk("refill_bk_rd", bk_rd, 1);
      chk("refill_bk_addr", bk_addr, ea);
      bk_ack = ack; bk_rdata = bkf(ea);
      if (inv) begin mv = '0; mkill = 1; end
      if (ack) begin
        mcnt++;
        if (mcnt == 4) begin
          mrefill = 0;
          li = int'((mbase >> 4) & 32'hF);
          if (!mkill) begin mv[li] = 1; mt[li] = mbase[31:8]; end
        end
      end
    end
    @(posedge i_clk); #1; cyc++;
  endtask
  task automatic fill(input logic [31:0] a);
    for (int i = 0; i < 4; i++) step(1, a, 0, 1);
  endtask
  task automatic mid_reset();
    mem_req_stb = 0; bk_ack = 0; inval = 0;
    #2 i_reset = 1;
    #1 chk("async_reset_bk_rd", bk_rd, 0);
    q.delete(); mv = '0; mrefill = 0; mkill = 0; mhits = 0; mmiss = 0; mcnt = 0;
    @(posedge i_clk); #1; i_reset = 0; cyc++;
  endtask
  always @(negedge i_clk) if (!i_reset) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++; failures++;
      $display("FAIL missing_valid cyc=%0d got=0 expected=1", q[0].cyc);
      void'(q.pop_front());
    end
    checks++;
    if (mem_req_valid) begin
      if (q.size() == 0 || q[0].cyc != cyc) begin
        failures++;
        $display("FAIL unexpected_valid cyc=%0d got=1 expected=0", cyc);
      end else if (mem_req_data !== q[0].d) begin
        failures++;
        $display("FAIL hit_data cyc=%0d got=%h expected=%h", cyc, mem_req_data, q[0].d);
        void'(q.pop_front());
      end else void'(q.pop_front());
    end else if (mem_req_data !== 32'h0) begin
      failures++;
      $display("FAIL idle_data cyc=%0d got=%h expected=0", cyc, mem_req_data);
    end
  end
  initial begin
    repeat (2) @(posedge i_clk);
    #1 i_reset = 0;
    chk("rst_bk_rd", bk_rd, 0);
    chk("rst_bk_addr", bk_addr, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_miss", miss_count, 0);
    step(1, 32'h100, 0, 1);
    chk("t1_miss", miss_count, 1);
    fill(32'h100);
    step(1, 32'h100, 0, 0);
    step(1, 32'h108, 0, 0);
    step(1, 32'h10E, 0, 0);
    chk("t2_hits", hit_count, 3);
    step(1, 32'h200, 0, 0);
    fill(32'h200);
    step(1, 32'h200, 0, 0);
    step(1, 32'h100, 0, 0);
    fill(32'h100);
    chk("t3_miss", miss_count, 3);
    step(1, 32'h310, 0, 0);
    for (int w = 0; w < 4; w++) begin
      repeat (3) step(1, 32'h310, 0, 0);
      step(1, 32'h310, 0, 1);
    end
    step(1, 32'h314, 0, 0);
    chk("t4_miss", miss_count, 4);
    step(1, 32'h100, 1, 0);
    step(1, 32'h100, 0, 0);
    chk("t5_inval_idle_miss", miss_count, 5);
    step(1, 32'h100, 0, 1);
    step(1, 32'h100, 1, 1);
    step(1, 32'h100, 0, 1);
    step(1, 32'h100, 0, 1);
    step(1, 32'h100, 0, 0);
    chk("t5_kill_miss", miss_count, 6);
    fill(32'h100);
    step(1, 32'h104, 0, 0);
    step(1, 32'h140, 0, 0);
    step(1, 32'h140, 0, 1);
    mid_reset();
    chk("t6_hits", hit_count, 0);
    chk("t6_miss", miss_count, 0);
    step(1, 32'h100, 0, 0);
    fill(32'h100);
    step(1, 32'h100, 0, 0);
    chk("t6_refill_miss", miss_count, 1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0,
           (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15)),
           $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 8 && mrefill; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("final_queue_empty", q.size(), 0);
    chk("final_hits", hit_count, mhits);
    chk("final_miss", miss_count, mmiss);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
